// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, phase encoding and phase decode for the LCD timer.
package lcd_timing_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_SETUP = 3'd1;
    localparam logic [2:0] PH_PULSE = 3'd2;
    localparam logic [2:0] PH_HOLD  = 3'd3;
    localparam logic [2:0] PH_WAIT  = 3'd4;

    localparam int DEF_CNT_W  = 12;
    localparam int DEF_PERIOD = 2081;
    localparam int DEF_SETUP  = 2;
    localparam int DEF_PULSE  = 12;
    localparam int DEF_HOLD   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    function automatic logic [2:0] phase_of(
        input int cnt,
        input int s,
        input int p,
        input int h
    );
        if (cnt < s)
            return PH_SETUP;
        else if (cnt < s + p)
            return PH_PULSE;
        else if (cnt < s + p + h)
            return PH_HOLD;
        return PH_WAIT;
    endfunction

endpackage

// File: rtl/lcd_cycle_counter.sv
// Wrapping 0..PERIOD-1 counter with clear, enable and terminal flag.
module lcd_cycle_counter #(
    parameter int CNT_W  = 12,
    parameter int PERIOD = 2081
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign term_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = term_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    // Next value lets the top register phase in step with the count.
    assign nxt_o = cnt_d;

endmodule

// File: rtl/lcd_cycle_timer.sv
// LCD instruction-cycle sequencer: IDLE/RUN FSM, phase decode and E strobe.
module lcd_cycle_timer
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int SETUP_CYC = DEF_SETUP,
    parameter int PULSE_CYC = DEF_PULSE,
    parameter int HOLD_CYC  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             auto_repeat,
    input  logic             abort,
    output logic [CNT_W-1:0] clk_cnt,
    output logic [2:0]       phase,
    output logic             lcd_e,
    output logic             busy,
    output logic             done
);

    if (PERIOD > 2 ** CNT_W ||
        SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 ||
        SETUP_CYC + PULSE_CYC + HOLD_CYC >= PERIOD) begin : g_bad_cfg
        $error("lcd_cycle_timer: illegal timing parameters");
    end

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             lcd_e_q, lcd_e_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] cnt_nxt;
    logic             term;
    logic             run;

    assign run = (state_q == ST_RUN);

    lcd_cycle_counter #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (abort | ~run),
        .en_i   (enable & run),
        .cnt_o  (clk_cnt),
        .nxt_o  (cnt_nxt),
        .term_o (term)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!abort && enable && start)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (enable && term) begin
                    done_d = 1'b1;
                    if (!auto_repeat)
                        state_d = ST_IDLE;
                end
            end
        endcase
        busy_d  = (state_d == ST_RUN);
        phase_d = PH_IDLE;
        if (busy_d)
            phase_d = phase_of(int'(cnt_nxt),
                               SETUP_CYC, PULSE_CYC, HOLD_CYC);
        lcd_e_d = (phase_d == PH_PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_IDLE;
            lcd_e_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lcd_e_q <= lcd_e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign phase = phase_q;
    assign lcd_e = lcd_e_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/lcd_cycle_timer.md
# lcd_cycle_timer

Parametrised instruction-cycle timer for the LCD controller. It generalises the fixed 0..2080 instruction clock counter into a start/done sequencer with a configurable period, a phase decode (setup, E pulse, hold, execution wait), one-shot or auto-repeat operation, pause, and abort. It sits between the instruction FSM and the LCD pin drivers. It owns the LCD `E` strobe and reports when the controller may issue the next instruction.

## Interface
- `CNT_W`, 12: counter width. Requires PERIOD ≤ 2^CNT_W.
- `PERIOD`, 2081: cycles per instruction; counter runs 0..PERIOD-1.
- `SETUP_CYC`, 2: cycles with E low before the pulse (RS/RW settle); ≥1.
- `PULSE_CYC`, 12: cycles with E high; ≥1.
- `HOLD_CYC`, 2: cycles with E low after the pulse, data held; ≥1.
- Constraint: SETUP_CYC+PULSE_CYC+HOLD_CYC < PERIOD. Violation is an elaboration error.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: count enable. Low freezes all state.
- `start` in 1: request one instruction cycle. Level-sampled.
- `auto_repeat` in 1: 1 means wrap and continue after PERIOD; 0 means one-shot.
- `abort` in 1: synchronous cancel.
- `clk_cnt` out CNT_W: current count.
- `phase` out 3: 0 IDLE, 1 SETUP, 2 PULSE, 3 HOLD, 4 WAIT.
- `lcd_e` out 1: LCD enable strobe.
- `busy` out 1: cycle in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE and RUN. Phase is decoded from `clk_cnt` while in RUN:
  - SETUP: cnt < S, where S = SETUP_CYC.
  - PULSE: S ≤ cnt < S+P, where P = PULSE_CYC.
  - HOLD: S+P ≤ cnt < S+P+H, where H = HOLD_CYC.
  - WAIT: otherwise, up to PERIOD-1.
- All outputs are registered. `phase` and `lcd_e` are computed from the next count, so they are always consistent with `clk_cnt` in the same cycle. `lcd_e` = (phase==PULSE).
- IDLE: `start`=1 and `enable`=1 → RUN next cycle, with cnt=0 and phase SETUP. `start` is ignored while in RUN.
- RUN with `enable`=1 and cnt<PERIOD-1 → cnt+1.
- RUN with `enable`=1 and cnt==PERIOD-1:
  - `done`=1 next cycle in either mode.
  - `auto_repeat`=1: cnt wraps to 0, stays in RUN, phase SETUP.
  - `auto_repeat`=0: return to IDLE with cnt=0.
- `enable`=0 holds cnt, phase, `lcd_e` and `busy`. It suppresses `done` and blocks `start`.
- `abort`=1:
  - Next cycle is IDLE with cnt=0, `lcd_e`=0, and no `done`.
  - `abort` takes priority over `enable`, `start` and terminal count.
  - `abort` together with `start` in IDLE: stays IDLE.
- `auto_repeat` is sampled only at terminal count; changes mid-cycle have no effect until then.
- Count arithmetic is unsigned CNT_W and never exceeds PERIOD-1.

## Timing
- Reset values: `clk_cnt`=0, `phase`=IDLE, `lcd_e`=0, `busy`=0, `done`=0.
- Start latency: `start` sampled at edge T → at T+1, `busy`=1, cnt=0, SETUP.
- Default parameters:
  - `lcd_e` is high for cnt 2..13 (12 cycles).
  - HOLD is cnt 14..15; WAIT is cnt 16..2080.
  - `done` rises PERIOD cycles after `busy` rises.
- One-shot: `busy` falls in the same cycle `done` is high. A `start` in that cycle is accepted, so back-to-back instructions have a gap of exactly 1 idle cycle.
- Auto-repeat: `busy` stays high; `done` pulses every PERIOD enabled cycles.
- `done` is never high for two consecutive cycles.
- Reset mid-cycle: outputs go to their reset values immediately (asynchronous), including `lcd_e`=0.

## Structure
- Shared package `lcd_timing_pkg` holds:
  - the phase encoding constants (IDLE..WAIT);
  - default timing constants (2081, 2, 12, 2);
  - a function computing phase from count.
- Sub-module `lcd_cycle_counter` is a wrapping counter with parameters CNT_W and PERIOD, inputs `clr`/`en`, and outputs count and a terminal flag. The top level holds the IDLE/RUN FSM, phase decode, and output registers.

## Test plan
- Reset asserted mid-PULSE at cnt=7 → all outputs 0 and IDLE at once. After release, a `start` gives cnt=0 / SETUP one cycle later.
- One-shot with defaults → `lcd_e` high exactly at cnt 2..13; `done` single pulse 2081 cycles after `busy` rose; then `busy`=0, cnt=0.
- `auto_repeat`=1 for 3 periods, `start` held high → `busy` never drops; cnt wraps 2080→0; 3 `done` pulses spaced 2081 cycles; extra `start` ignored.
- `enable` low for 50 cycles at cnt=5 (PULSE) → cnt stays 5 and `lcd_e` stays 1; `done` is delayed by exactly 50 cycles.
- `abort` at cnt=2080 with `auto_repeat`=1, then `abort`+`start` together in IDLE → IDLE next cycle, no `done`, still IDLE after the combined request.
- Alternate parameters: CNT_W=4, PERIOD=10, S=1, P=3, H=1 → phases at cnt 0 / 1-3 / 4 / 5-9. PERIOD=17 with CNT_W=4 fails elaboration.
